// File: rtl/alu_hs.sv
// alu_hs -- handshaked ALU with registered result and flags.
//
// Sits between operand fetch and write-back. A new op is taken when
// in_valid && in_ready; the result and flags stay registered and stable
// until the consumer takes them with out_ready. A result may be consumed
// and a new op accepted on the same edge, so back-to-back ops run with
// no bubble.
//
// Optional feature macro: ALU_HS_MUL_EN
//   defined   : op 1000 (unsigned MUL, low N bits) runs on an iterative
//               shift-add unit, one step per cycle for N cycles (BUSY state).
//   undefined : no multiplier is built; op 1000 is illegal (out=0, err=1).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake; inA, inB operands, op operation code
//   out_valid/out_ready output handshake
//   out               registered result
//   zero/carry/ovf/neg/err  registered flags qualified by out_valid
module alu_hs #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         zero,
    output logic         carry,
    output logic         ovf,
    output logic         neg,
    output logic         err
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_HS_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int         CW     = $clog2(N);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_HS_MUL_EN
        BUSY = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [N:0]   sum, diff;
    logic [N-1:0] res;
    logic         res_c, res_v, res_e;
    logic         is_mul;

    always_comb begin
        // Extra top bit gives the add carry-out and, for SUB, the borrow
        // (set exactly when A < B unsigned).
        sum    = {1'b0, inA} + {1'b0, inB};
        diff   = {1'b0, inA} - {1'b0, inB};
        res    = '0;
        res_c  = 1'b0;
        res_v  = 1'b0;
        res_e  = 1'b0;
        is_mul = 1'b0;
        case (op)
            OP_AND: res = inA & inB;
            OP_OR:  res = inA | inB;
            OP_NOR: res = ~(inA | inB);
            OP_ADD: begin
                res   = sum[N-1:0];
                res_c = sum[N];
                res_v = (inA[N-1] == inB[N-1]) && (res[N-1] != inA[N-1]);
            end
            OP_SUB: begin
                res   = diff[N-1:0];
                res_c = diff[N];
                res_v = (inA[N-1] != inB[N-1]) && (res[N-1] != inA[N-1]);
            end
            OP_SLT: res = {{(N-1){1'b0}}, ($signed(inA) < $signed(inB))};
`ifdef ALU_HS_MUL_EN
            OP_MUL: is_mul = 1'b1;
`endif
            default: res_e = 1'b1;
        endcase
    end

`ifdef ALU_HS_MUL_EN
    // ------------------------------------------------------------------
    // Shift-add multiplier: acc holds {partial product, remaining
    // multiplier bits}. Each step conditionally adds A into the upper
    // half (keeping its carry) and shifts the whole thing right by one.
    // ------------------------------------------------------------------
    logic [N-1:0]   mul_a;
    logic [2*N-1:0] acc, acc_next;
    logic [N:0]     mul_add;
    logic [CW-1:0]  cnt;

    always_comb begin
        mul_add  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mul_a} : {(N+1){1'b0}});
        acc_next = {mul_add, acc[N-1:1]};
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic accept, load, mul_start, mul_fin;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        mul_start  = 1'b0;
        mul_fin    = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
`ifdef ALU_HS_MUL_EN
            BUSY: begin
                if (cnt == CW'(N-1)) begin
                    mul_fin    = 1'b1;
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready && !in_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        accept = in_valid && in_ready;
        if (accept) begin
`ifdef ALU_HS_MUL_EN
            if (is_mul) begin
                mul_start  = 1'b1;
                state_next = BUSY;
            end else begin
                load       = 1'b1;
                state_next = DONE;
            end
`else
            load       = 1'b1;
            state_next = DONE;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Result / flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            neg   <= 1'b0;
            err   <= 1'b0;
`ifdef ALU_HS_MUL_EN
            mul_a <= '0;
            acc   <= '0;
            cnt   <= '0;
`endif
        end else begin
            if (load) begin
                out   <= res;
                zero  <= (res == '0);
                carry <= res_c;
                ovf   <= res_v;
                neg   <= res[N-1];
                err   <= res_e;
            end
`ifdef ALU_HS_MUL_EN
            if (mul_start) begin
                mul_a <= inA;
                acc   <= {{N{1'b0}}, inB};
                cnt   <= '0;
            end else if (state == BUSY) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
            end
            if (mul_fin) begin
                out   <= acc_next[N-1:0];
                zero  <= (acc_next[N-1:0] == '0);
                carry <= |acc_next[2*N-1:N];
                ovf   <= 1'b0;
                neg   <= acc_next[N-1];
                err   <= 1'b0;
            end
`endif
        end
    end

endmodule
